// File: rtl/rv32i_decoder_if.sv
// rtl/rv32i_decoder_if.sv - instruction word in, decoded control fields out
interface rv32i_decoder_if;
    logic [31:0] ir;
    logic [4:0]  srcreg1_num;
    logic [4:0]  srcreg2_num;
    logic [4:0]  dstreg_num;
    logic [31:0] imm;
    logic [5:0]  alucode;
    logic [1:0]  aluop1_type;
    logic [1:0]  aluop2_type;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_halt;

    // fetch side: supplies the instruction, consumes the decode
    modport master (
        output ir,
        input  srcreg1_num, srcreg2_num, dstreg_num, imm, alucode,
        input  aluop1_type, aluop2_type, reg_we, is_load, is_store, is_halt
    );

    // decoder side
    modport slave (
        input  ir,
        output srcreg1_num, srcreg2_num, dstreg_num, imm, alucode,
        output aluop1_type, aluop2_type, reg_we, is_load, is_store, is_halt
    );
endinterface

// File: rtl/rv32i_decoder.sv
// rtl/rv32i_decoder.sv - combinational RV32I decoder with sticky halt flag
module rv32i_decoder (
    input  logic             clk,
    input  logic             rst_n,
    rv32i_decoder_if.slave   bus
);
    localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2;
    localparam logic [5:0] ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5;
    localparam logic [5:0] ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8;
    localparam logic [5:0] ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
    localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14;
    localparam logic [5:0] ALU_SH   = 6'd15, ALU_SW   = 6'd16, ALU_ADD  = 6'd17;
    localparam logic [5:0] ALU_SUB  = 6'd18, ALU_SLT  = 6'd19, ALU_SLTU = 6'd20;
    localparam logic [5:0] ALU_XOR  = 6'd21, ALU_OR   = 6'd22, ALU_AND  = 6'd23;
    localparam logic [5:0] ALU_SLL  = 6'd24, ALU_SRL  = 6'd25, ALU_SRA  = 6'd26;
    localparam logic [5:0] ALU_NOP  = 6'd63;

    localparam logic [1:0] OP_NONE = 2'd0, OP_REG = 2'd1, OP_IMM = 2'd2, OP_PC = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011, OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [31:0] ir;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [31:0] d_imm;
    logic [5:0]  d_alu;
    logic [1:0]  d_t1, d_t2;
    logic        d_we, d_load, d_store;
    logic        halt_decode, halted;

    assign ir     = bus.ir;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign rd     = ir[11:7];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_sh = {27'b0, ir[24:20]};

    // Field decode: pick the ALU op first; fields are only driven when the op is legal
    always_comb begin
        d_alu = ALU_NOP;
        d_rs1 = 5'd0;
        d_rs2 = 5'd0;
        d_rd  = 5'd0;
        d_imm = 32'd0;
        d_t1  = OP_NONE;
        d_t2  = OP_NONE;
        d_we  = 1'b0;
        d_load  = 1'b0;
        d_store = 1'b0;
        halt_decode = (ir == 32'h0000_0073) || (ir == 32'h0010_0073);

        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'd0: d_alu = ALU_ADD;
                        3'd1: d_alu = ALU_SLL;
                        3'd2: d_alu = ALU_SLT;
                        3'd3: d_alu = ALU_SLTU;
                        3'd4: d_alu = ALU_XOR;
                        3'd5: d_alu = ALU_SRL;
                        3'd6: d_alu = ALU_OR;
                        default: d_alu = ALU_AND;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    d_alu = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    d_alu = ALU_SRA;
                end
                if (d_alu != ALU_NOP) begin
                    d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
                    d_t1 = OP_REG; d_t2 = OP_REG; d_we = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d_imm = imm_i;
                case (funct3)
                    3'd0: d_alu = ALU_ADD;
                    3'd1: begin
                        d_imm = imm_sh;
                        if (funct7 == 7'h00) d_alu = ALU_SLL;
                    end
                    3'd2: d_alu = ALU_SLT;
                    3'd3: d_alu = ALU_SLTU;
                    3'd4: d_alu = ALU_XOR;
                    3'd5: begin
                        d_imm = imm_sh;
                        if (funct7 == 7'h00)      d_alu = ALU_SRL;
                        else if (funct7 == 7'h20) d_alu = ALU_SRA;
                    end
                    3'd6: d_alu = ALU_OR;
                    default: d_alu = ALU_AND;
                endcase
                if (d_alu != ALU_NOP) begin
                    d_rs1 = rs1; d_rd = rd;
                    d_t1 = OP_REG; d_t2 = OP_IMM; d_we = 1'b1;
                end else begin
                    d_imm = 32'd0;
                end
            end
            OPC_LUI: begin
                d_alu = ALU_LUI; d_rd = rd; d_imm = imm_u;
                d_t1 = OP_NONE; d_t2 = OP_IMM; d_we = 1'b1;
            end
            OPC_AUIPC: begin
                d_alu = ALU_ADD; d_rd = rd; d_imm = imm_u;
                d_t1 = OP_IMM; d_t2 = OP_PC; d_we = 1'b1;
            end
            OPC_LOAD: begin
                case (funct3)
                    3'd0: d_alu = ALU_LB;
                    3'd1: d_alu = ALU_LH;
                    3'd2: d_alu = ALU_LW;
                    3'd4: d_alu = ALU_LBU;
                    3'd5: d_alu = ALU_LHU;
                    default: d_alu = ALU_NOP;
                endcase
                if (d_alu != ALU_NOP) begin
                    d_rs1 = rs1; d_rd = rd; d_imm = imm_i;
                    d_t1 = OP_REG; d_t2 = OP_IMM; d_we = 1'b1; d_load = 1'b1;
                end
            end
            OPC_STORE: begin
                case (funct3)
                    3'd0: d_alu = ALU_SB;
                    3'd1: d_alu = ALU_SH;
                    3'd2: d_alu = ALU_SW;
                    default: d_alu = ALU_NOP;
                endcase
                if (d_alu != ALU_NOP) begin
                    d_rs1 = rs1; d_rs2 = rs2; d_imm = imm_s;
                    d_t1 = OP_REG; d_t2 = OP_IMM; d_store = 1'b1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'd0: d_alu = ALU_BEQ;
                    3'd1: d_alu = ALU_BNE;
                    3'd4: d_alu = ALU_BLT;
                    3'd5: d_alu = ALU_BGE;
                    3'd6: d_alu = ALU_BLTU;
                    3'd7: d_alu = ALU_BGEU;
                    default: d_alu = ALU_NOP;
                endcase
                if (d_alu != ALU_NOP) begin
                    d_rs1 = rs1; d_rs2 = rs2; d_imm = imm_b;
                    d_t1 = OP_REG; d_t2 = OP_REG;
                end
            end
            OPC_JAL: begin
                d_alu = ALU_JAL; d_rd = rd; d_imm = imm_j;
                d_t1 = OP_NONE; d_t2 = OP_PC; d_we = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'd0) begin
                    d_alu = ALU_JALR; d_rs1 = rs1; d_rd = rd; d_imm = imm_i;
                    d_t1 = OP_REG; d_t2 = OP_PC; d_we = 1'b1;
                end
            end
            default: d_alu = ALU_NOP;
        endcase
    end

    // Sticky halt: once ECALL/EBREAK is seen on a clock edge, stay halted until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           halted <= 1'b0;
        else if (halt_decode) halted <= 1'b1;
    end

    // Output stage: reset blanks everything; writes to x0 are suppressed
    always_comb begin
        bus.srcreg1_num = rst_n ? d_rs1 : 5'd0;
        bus.srcreg2_num = rst_n ? d_rs2 : 5'd0;
        bus.dstreg_num  = rst_n ? d_rd  : 5'd0;
        bus.imm         = rst_n ? d_imm : 32'd0;
        bus.alucode     = rst_n ? d_alu : ALU_LUI;
        bus.aluop1_type = rst_n ? d_t1  : OP_NONE;
        bus.aluop2_type = rst_n ? d_t2  : OP_NONE;
        bus.reg_we      = rst_n && d_we && (d_rd != 5'd0);
        bus.is_load     = rst_n && d_load;
        bus.is_store    = rst_n && d_store;
        bus.is_halt     = rst_n && (halt_decode || halted);
    end
endmodule

// File: tb/tb_rv32i_decoder.sv
// tb/tb_rv32i_decoder.sv - randomized and directed checks of rv32i_decoder against a reference model
module tb_rv32i_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_decoder_if bus ();
    rv32i_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  alu;
        logic [1:0]  t1;
        logic [1:0]  t2;
        logic        we;
        logic        ld;
        logic        st;
        logic        halt;
    } dec_t;

    int n_checks = 0;
    int n_fail = 0;
    logic model_halted = 1'b0;

    // ALU numbering tables indexed by funct3 (-1: illegal)
    int op_tab  [16] = '{17, 24, 19, 20, 21, 25, 22, 23, 18, -1, -1, -1, -1, 26, -1, -1};
    int imm_tab [8]  = '{17, -1, 19, 20, 21, -1, 22, 23};
    int ld_tab  [8]  = '{9, 10, 11, -1, 12, 13, -1, -1};
    int st_tab  [8]  = '{14, 15, 16, -1, -1, -1, -1, -1};
    int br_tab  [8]  = '{3, 4, -1, -1, 5, 6, 7, 8};
    int opc_list [10] = '{'h33, 'h13, 'h37, 'h17, 'h03, 'h23, 'h63, 'h6f, 'h67, 'h73};

    // interpret an unsigned field value as a two's-complement number of the given width
    function automatic int sx(input int v, input int bits);
        int r;
        r = v;
        if (v >= (1 << (bits - 1))) r = v - (1 << bits);
        return r;
    endfunction

    function automatic bit is_halt_word(input logic [31:0] w);
        return (w == 32'h0000_0073) || (w == 32'h0010_0073);
    endfunction

    function automatic dec_t model(input logic [31:0] w, input logic h, input logic rn);
        dec_t d;
        int alu, opc, f3, f7, v_rs1, v_rs2, v_rd, i_imm;
        d = '0;
        alu = -1;
        opc = int'(w[6:0]);  f3 = int'(w[14:12]); f7 = int'(w[31:25]);
        v_rs1 = int'(w[19:15]); v_rs2 = int'(w[24:20]); v_rd = int'(w[11:7]);
        i_imm = sx(int'(w[31:20]), 12);
        case (opc)
            'h33: begin
                if (f7 == 0 || f7 == 32) alu = op_tab[(f7 / 32) * 8 + f3];
                d.rs1 = v_rs1[4:0]; d.rs2 = v_rs2[4:0]; d.rd = v_rd[4:0];
                d.t1 = 1; d.t2 = 1; d.we = 1;
            end
            'h13: begin
                if (f3 == 1)      alu = (f7 == 0) ? 24 : -1;
                else if (f3 == 5) alu = (f7 == 0) ? 25 : ((f7 == 32) ? 26 : -1);
                else              alu = imm_tab[f3];
                d.rs1 = v_rs1[4:0]; d.rd = v_rd[4:0];
                d.imm = (f3 == 1 || f3 == 5) ? 32'(v_rs2) : 32'(i_imm);
                d.t1 = 1; d.t2 = 2; d.we = 1;
            end
            'h37, 'h17: begin
                alu = (opc == 'h37) ? 0 : 17;
                d.rd = v_rd[4:0]; d.imm = w & 32'hffff_f000;
                d.t1 = (opc == 'h37) ? 2'd0 : 2'd2;
                d.t2 = (opc == 'h37) ? 2'd2 : 2'd3;
                d.we = 1;
            end
            'h03: begin
                alu = ld_tab[f3];
                d.rs1 = v_rs1[4:0]; d.rd = v_rd[4:0]; d.imm = 32'(i_imm);
                d.t1 = 1; d.t2 = 2; d.we = 1; d.ld = 1;
            end
            'h23: begin
                alu = st_tab[f3];
                d.rs1 = v_rs1[4:0]; d.rs2 = v_rs2[4:0];
                d.imm = 32'(sx(f7 * 32 + v_rd, 12));
                d.t1 = 1; d.t2 = 2; d.st = 1;
            end
            'h63: begin
                alu = br_tab[f3];
                d.rs1 = v_rs1[4:0]; d.rs2 = v_rs2[4:0];
                d.imm = 32'(sx(int'(w[31]) * 4096 + int'(w[7]) * 2048
                             + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13));
                d.t1 = 1; d.t2 = 1;
            end
            'h6f: begin
                alu = 1;
                d.rd = v_rd[4:0];
                d.imm = 32'(sx(int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096
                             + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21));
                d.t1 = 0; d.t2 = 3; d.we = 1;
            end
            'h67: begin
                alu = (f3 == 0) ? 2 : -1;
                d.rs1 = v_rs1[4:0]; d.rd = v_rd[4:0]; d.imm = 32'(i_imm);
                d.t1 = 1; d.t2 = 3; d.we = 1;
            end
            default: alu = -1;
        endcase
        if (alu < 0) begin
            d = '0;
            alu = 63;
        end
        d.alu = alu[5:0];
        d.we = d.we && (d.rd != 0);
        d.halt = is_halt_word(w) || h;
        if (!rn) d = '0;
        return d;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] w;
        int k, opc;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 10) begin
            opc = opc_list[k];
            w[6:0] = opc[6:0];
            if ((opc == 'h33 || opc == 'h13) && $urandom_range(0, 3) != 0)
                w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if (opc == 'h73) begin
                case ($urandom_range(0, 7))
                    0: w = 32'h0000_0073;
                    1: w = 32'h0010_0073;
                    default: w[6:0] = 7'h73;
                endcase
            end else if ($urandom_range(0, 7) == 0) begin
                w[11:7] = 5'd0;
            end
        end
        return w;
    endfunction

    // reference sticky-halt flag
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    model_halted <= 1'b0;
        else if (is_halt_word(bus.ir)) model_halted <= 1'b1;
    end

    // every-cycle comparison of the whole decoded bundle
    always @(negedge clk) begin
        dec_t a, e;
        a = {bus.srcreg1_num, bus.srcreg2_num, bus.dstreg_num, bus.imm, bus.alucode,
             bus.aluop1_type, bus.aluop2_type, bus.reg_we, bus.is_load, bus.is_store, bus.is_halt};
        e = model(bus.ir, model_halted, rst_n);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_compare ir=%h actual=%h required=%h", bus.ir, a, e);
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] w);
        @(posedge clk);
        #1 bus.ir = w;
        #3;
    endtask

    initial begin
        dec_t m;
        bus.ir = 32'h00b5_0633;
        #2;
        pin("reset_alucode", 32'(bus.alucode), 32'd0);
        pin("reset_dst", 32'(bus.dstreg_num), 32'd0);
        pin("reset_we", 32'(bus.reg_we), 32'd0);
        #5 rst_n = 1'b1;

        m = model(32'hfec5_84e3, 1'b0, 1'b1);
        pin("model_beq_imm", m.imm, 32'hffff_ffe8);
        m = model(32'h0080_00ef, 1'b0, 1'b1);
        pin("model_jal_imm", m.imm, 32'd8);

        apply(32'h00b5_0633);
        pin("add_alu", 32'(bus.alucode), 32'd17);
        pin("add_src", {bus.srcreg1_num, bus.srcreg2_num}, {22'd0, 5'd10, 5'd11});
        pin("add_dst", 32'(bus.dstreg_num), 32'd12);
        pin("add_types", {bus.aluop1_type, bus.aluop2_type, bus.reg_we}, 32'b01_01_1);
        apply(32'h40b5_d7b3);
        pin("sra_alu", 32'(bus.alucode), 32'd26);
        pin("sra_regs", {bus.srcreg1_num, bus.srcreg2_num, bus.dstreg_num}, {17'd0, 5'd11, 5'd11, 5'd15});
        apply(32'hfff0_0513);
        pin("addi_imm", bus.imm, 32'hffff_ffff);
        pin("addi_types", {bus.alucode, bus.aluop1_type, bus.aluop2_type}, {22'd0, 6'd17, 2'd1, 2'd2});
        apply(32'h4015_d793);
        pin("srai", {bus.alucode, bus.imm[7:0]}, {18'd0, 6'd26, 8'd1});
        apply(32'h8088_05b7);
        pin("lui_imm", bus.imm, 32'h8088_0000);
        pin("lui_types", {bus.alucode, bus.aluop1_type, bus.aluop2_type}, {22'd0, 6'd0, 2'd0, 2'd2});
        apply(32'h0000_0817);
        pin("auipc", {bus.alucode, bus.aluop1_type, bus.aluop2_type, bus.dstreg_num}, {17'd0, 6'd17, 2'd2, 2'd3, 5'd16});
        apply(32'h00b5_10a3);
        pin("sh_alu_imm", {bus.alucode, bus.imm[7:0]}, {18'd0, 6'd15, 8'd1});
        pin("sh_strobes", {bus.is_store, bus.reg_we, bus.dstreg_num}, {25'd0, 1'b1, 1'b0, 5'd0});
        apply(32'h0035_4683);
        pin("lbu", {bus.alucode, bus.dstreg_num, bus.imm[7:0], bus.is_load, bus.reg_we},
            {11'd0, 6'd12, 5'd13, 8'd3, 1'b1, 1'b1});
        apply(32'hfec5_84e3);
        pin("beq_imm", bus.imm, 32'hffff_ffe8);
        pin("beq_fields", {bus.alucode, bus.srcreg1_num, bus.srcreg2_num, bus.reg_we}, {15'd0, 6'd3, 5'd11, 5'd12, 1'b0});
        apply(32'hf8e5_72e3);
        pin("bgeu_imm", bus.imm, 32'hffff_ff84);
        pin("bgeu_alu", 32'(bus.alucode), 32'd8);
        apply(32'h0080_00ef);
        pin("jal", {bus.alucode, bus.dstreg_num, bus.aluop1_type, bus.aluop2_type, bus.reg_we},
            {16'd0, 6'd1, 5'd1, 2'd0, 2'd3, 1'b1});
        pin("jal_imm", bus.imm, 32'd8);
        apply(32'h00c0_006f);
        pin("jal_x0", {bus.dstreg_num, bus.imm[7:0], bus.reg_we}, {18'd0, 5'd0, 8'd12, 1'b0});
        apply(32'h00c0_8067);
        pin("jalr_x0", {bus.alucode, bus.srcreg1_num, bus.imm[7:0], bus.reg_we}, {12'd0, 6'd2, 5'd1, 8'd12, 1'b0});

        apply(32'h0000_0073);
        pin("ecall_halt", {bus.is_halt, bus.alucode}, {25'd0, 1'b1, 6'd63});
        apply(32'h00b5_0633);
        pin("halt_sticky", {bus.is_halt, bus.alucode}, {25'd0, 1'b1, 6'd17});
        rst_n = 1'b0;
        #2;
        pin("reset_halt", 32'(bus.is_halt), 32'd0);
        pin("reset_outputs", {bus.alucode, bus.dstreg_num, bus.srcreg1_num, bus.reg_we}, 32'd0);
        pin("reset_imm", bus.imm, 32'd0);
        rst_n = 1'b1;
        #2;
        pin("release_decode", {bus.is_halt, bus.alucode}, {25'd0, 1'b0, 6'd17});

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.ir = rand_ir();
            rst_n = ((i % 40) == 39) ? 1'b0 : 1'b1;
        end
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
